mac_sequencer: RTL

Run-level controller for the `MAC` systolic array. It accepts a start command with mode and vector count, reads operand vectors from the vertical and horizontal operand buffers, and skews each lane into the array edge, inserting zeros when no data is present. It clears the PE accumulators before each run, waits out array fill and drain, then signals completion. It sits between the operand buffers and the array inputs `vertical_input`, `horizontal_input`, `i_mode` and `rst`.

---
 rtl/mac_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: run-level controller for the MAC systolic array.
// Accepts a start command, clears the PE accumulators, streams K operand
// vectors from the operand buffers into the array edge with per-lane skew,
// waits for the array to fill and drain, then pulses done.
//
// Handshake semantics: start is a level request that is honoured only in
// IDLE (there is no ready/ack and no queuing; requests seen in any other
// state are dropped). buf_rd_en is a fire-and-forget read strobe with no
// backpressure: the operand buffers return the addressed word on
// vbuf_data/hbuf_data exactly one cycle after buf_rd_en is high.
module mac_sequencer #(
  parameter int ARR_SIZE      = 4,
  parameter int VERTICAL_BW   = 32,
  parameter int HORIZONTAL_BW = 16,
  parameter int LEN_W         = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              cfg_mode,
  input  logic [LEN_W-1:0]                  cfg_len,
  output logic                              busy,
  output logic                              done,
  output logic                              buf_rd_en,
  output logic [LEN_W-1:0]                  buf_rd_addr,
  input  logic [VERTICAL_BW*ARR_SIZE-1:0]   vbuf_data,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] hbuf_data,
  output logic [VERTICAL_BW*ARR_SIZE-1:0]   arr_vertical,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] arr_horizontal,
  output logic                              arr_mode,
  output logic                              arr_rst,
  output logic [2:0]                        dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Drain covers 1 cycle of buffer latency, N-1 cycles of lane skew and
  // 2N-1 cycles of propagation through the array: 3N-1 cycles total.
  localparam int             DRAIN_CYCLES = 3 * ARR_SIZE - 1;
  localparam int             DCW          = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD   = DCW'(DRAIN_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [LEN_W-1:0] k_len;
  logic [LEN_W-1:0] addr;
  logic [DCW-1:0]   drain_cnt;
  logic             last_feed;
  logic             d_vld;

  // Last read of the run is the one at address K-1 (only meaningful in FEED,
  // where K is known to be non-zero).
  assign last_feed = (addr == (k_len - LEN_W'(1)));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = (k_len != '0) ? S_FEED : S_DONE;
      S_FEED:  if (last_feed) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Run configuration, captured only on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      k_len    <= '0;
      arr_mode <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      k_len    <= cfg_len;
      arr_mode <= cfg_mode;
    end
  end

  // Read address walks 0..K-1 during FEED and parks at 0 otherwise
  always_ff @(posedge clk) begin
    if (rst)                  addr <= '0;
    else if (state == S_FEED) addr <= last_feed ? '0 : addr + LEN_W'(1);
    else                      addr <= '0;
  end

  // Drain down-counter, loaded as FEED hands over to DRAIN
  always_ff @(posedge clk) begin
    if (rst)                                     drain_cnt <= '0;
    else if ((state == S_FEED) && last_feed)     drain_cnt <= DRAIN_LOAD;
    else if ((state == S_DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - DCW'(1);
  end

  // Buffer data is valid the cycle after a read strobe
  always_ff @(posedge clk) begin
    if (rst) d_vld <= 1'b0;
    else     d_vld <= buf_rd_en;
  end

  // Decoded status outputs
  always_comb begin
    busy        = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    done        = (state == S_DONE);
    buf_rd_en   = (state == S_FEED);
    buf_rd_addr = addr;
    arr_rst     = rst || (state == S_CLEAR);
    dbg_state   = state;
  end

  // Skew path: each lane is zero-gated while no buffer data is valid, then
  // delayed by its lane index so the operands enter the array diagonally.
  // Gating ahead of the delay chain makes idle cycles flow through as zeros.
  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    logic [VERTICAL_BW-1:0]   v_gated;
    logic [HORIZONTAL_BW-1:0] h_gated;

    assign v_gated = d_vld ? vbuf_data[i*VERTICAL_BW +: VERTICAL_BW] : '0;
    assign h_gated = d_vld ? hbuf_data[i*HORIZONTAL_BW +: HORIZONTAL_BW] : '0;

    if (i == 0) begin : g_direct
      assign arr_vertical[VERTICAL_BW-1:0]     = v_gated;
      assign arr_horizontal[HORIZONTAL_BW-1:0] = h_gated;
    end else begin : g_delay
      logic [VERTICAL_BW-1:0]   v_pipe [i];
      logic [HORIZONTAL_BW-1:0] h_pipe [i];

      // Lane-i delay chain of i registers, cleared by reset
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < i; j++) begin
            v_pipe[j] <= '0;
            h_pipe[j] <= '0;
          end
        end else begin
          v_pipe[0] <= v_gated;
          h_pipe[0] <= h_gated;
          for (int j = 1; j < i; j++) begin
            v_pipe[j] <= v_pipe[j-1];
            h_pipe[j] <= h_pipe[j-1];
          end
        end
      end

      assign arr_vertical[i*VERTICAL_BW +: VERTICAL_BW]       = v_pipe[i-1];
      assign arr_horizontal[i*HORIZONTAL_BW +: HORIZONTAL_BW] = h_pipe[i-1];
    end
  end

endmodule
